// File: rtl/axis_frame_len_arb.sv
// Collects one-cycle frame length results from several monitors into per-channel
// pending slots and drains them round-robin onto one valid/ready status stream.
module axis_frame_len_arb #(
   parameter int unsigned PORTS          = 4,
   parameter int unsigned LEN_WIDTH      = 16,
   parameter int unsigned DROP_CNT_WIDTH = 8,
   parameter int unsigned PORT_WIDTH     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [PORTS*LEN_WIDTH-1:0]        in_frame_len,
   input  logic [PORTS-1:0]                  in_frame_len_valid,
   output logic [LEN_WIDTH-1:0]              out_frame_len,
   output logic [PORT_WIDTH-1:0]             out_port,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [PORTS-1:0]                  drop,
   output logic [PORTS*DROP_CNT_WIDTH-1:0]   drop_count,
   input  logic                              clear_drop
);

   localparam logic [DROP_CNT_WIDTH-1:0] CNT_MAX = {DROP_CNT_WIDTH{1'b1}};
   localparam logic [PORT_WIDTH-1:0]     LAST_RST = PORT_WIDTH'(PORTS - 1);

   logic [PORTS-1:0]                 pend_valid;
   logic [PORTS-1:0][LEN_WIDTH-1:0]  pend_len;
   logic [PORT_WIDTH-1:0]            last;

   logic                             loadable_c;
   logic                             any_pend_c;
   logic [PORT_WIDTH-1:0]            sel_c;
   logic [PORTS-1:0]                 grant_c;
   logic [PORTS-1:0]                 accept_c;
   logic [PORTS-1:0]                 lost_c;

   // Round-robin pick: first pending slot after the last grant, wrapping.
   always_comb begin
      int unsigned idx;
      any_pend_c = 1'b0;
      sel_c      = '0;
      idx        = 0;
      for (int unsigned k = 1; k <= PORTS; k++) begin
         idx = (32'(last) + k) % PORTS;
         if (!any_pend_c && pend_valid[idx]) begin
            any_pend_c = 1'b1;
            sel_c      = PORT_WIDTH'(idx);
         end
      end
   end

   assign loadable_c = !out_valid || out_ready;

   always_comb begin
      grant_c = '0;
      if (loadable_c && any_pend_c) begin
         grant_c[sel_c] = 1'b1;
      end
   end

   // A slot being granted this cycle can take a new result without loss.
   assign accept_c = in_frame_len_valid & (~pend_valid | grant_c);
   assign lost_c   = in_frame_len_valid & ~accept_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid <= '0;
         pend_len   <= '0;
      end else begin
         for (int i = 0; i < int'(PORTS); i++) begin
            if (accept_c[i]) begin
               pend_valid[i] <= 1'b1;
               pend_len[i]   <= in_frame_len[i*LEN_WIDTH +: LEN_WIDTH];
            end else if (grant_c[i]) begin
               pend_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Output stage; holds while stalled, empties when nothing is pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_frame_len <= '0;
         out_port      <= '0;
         last          <= LAST_RST;
      end else if (loadable_c) begin
         if (any_pend_c) begin
            out_valid     <= 1'b1;
            out_frame_len <= pend_len[sel_c];
            out_port      <= sel_c;
            last          <= sel_c;
         end else begin
            out_valid     <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop       <= '0;
         drop_count <= '0;
      end else begin
         drop <= lost_c;
         for (int i = 0; i < int'(PORTS); i++) begin
            if (clear_drop) begin
               drop_count[i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] <=
                  lost_c[i] ? DROP_CNT_WIDTH'(1) : '0;
            end else if (lost_c[i] &&
                         drop_count[i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] != CNT_MAX) begin
               drop_count[i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] <=
                  drop_count[i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] + DROP_CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: doc/axis_frame_len_arb.md
# axis_frame_len_arb

Status arbiter for multiple per-stream frame length monitors. It captures the one-cycle `frame_len`/`frame_len_valid` result pulses from up to `PORTS` monitors, which have no backpressure, into one pending slot per channel. It then schedules them round-robin onto a single valid/ready status stream toward the statistics/CSR logic. Results that cannot be buffered are dropped and counted per channel.

## Interface
- `PORTS`, 4: number of monitor channels (≥1).
- `LEN_WIDTH`, 16: frame length width.
- `DROP_CNT_WIDTH`, 8: width of each per-channel saturating drop counter.
- `PORT_WIDTH`, `PORTS>1 ? $clog2(PORTS) : 1`: width of the channel index.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_frame_len`  in  `PORTS*LEN_WIDTH`  per-channel length; channel i occupies bits `[i*LEN_WIDTH +: LEN_WIDTH]`.
- `in_frame_len_valid`  in  `PORTS`  per-channel one-cycle result strobe.
- `out_frame_len`  out  `LEN_WIDTH`  granted length.
- `out_port`  out  `PORT_WIDTH`  channel index of the granted result.
- `out_valid`  out  1  output holds a result.
- `out_ready`  in  1  sink accepts the result.
- `drop`  out  `PORTS`  one-cycle pulse per channel when a result is lost.
- `drop_count`  out  `PORTS*DROP_CNT_WIDTH`  per-channel saturating drop count.
- `clear_drop`  in  1  zeroes all drop counters.

## Operation
- **Pending slots**
  - Each channel has one slot holding a valid bit and a length.
  - On `in_frame_len_valid[i]`, the length is captured if the slot is empty, or if the slot is granted in that same cycle. A slot freed and refilled in the same cycle is not a drop.
  - Otherwise the new result is discarded and the slot keeps its older value. `drop[i]` pulses the next cycle and `drop_count[i]` increments, saturating at all-ones.
- **Output register**
  - A single stage holding `out_frame_len`, `out_port` and `out_valid`.
  - It is loadable when `!out_valid` or `out_ready`. A transfer happens when `out_valid && out_ready`.
  - When loadable and at least one slot is pending, the arbiter grants one channel: its slot moves to the output register and the slot is freed.
  - When loadable and nothing is pending, `out_valid` goes to 0.
  - While `out_valid && !out_ready`, all outputs are held stable.
- **Round-robin arbitration**
  - The arbiter keeps a last-grant pointer `last`.
  - Priority order is `last+1, last+2, …` modulo `PORTS`.
  - `last` updates only on a grant.
  - Reset value of `last` is `PORTS-1`, so channel 0 has highest priority first.
- **Drop counters**
  - `clear_drop` sets all counters to 0 next cycle.
  - If `clear_drop` and a drop on channel i occur in the same cycle, `drop_count[i]` becomes 1.
- **Reset values**
  - Outputs: `out_valid`=0, `out_frame_len`=0, `out_port`=0, `drop`=0, all `drop_count`=0.
  - Internal: all slots empty, `last`=`PORTS-1`.
  - Reset mid-operation discards pending and output data without any drop pulse.
- **Width rules**
  - Lengths pass through unmodified.
  - Counters saturate and never wrap.

## Timing
- Strobe on `in_frame_len_valid[i]` at cycle t gives pending at t+1. The grant is evaluated at t+1, so the earliest `out_valid` is t+2. Latency is 2 cycles when uncontended.
- With `out_ready` held at 1, sustained throughput is one result per cycle across channels.
- Worst case, a pending result waits `PORTS-1` grants after any currently valid output.
- Capacity per channel is one slot plus, when that channel holds the output register, one output entry.
- `drop` is registered and asserts in cycle t+1 for a dropped strobe at t.
- All outputs are registered. No combinational path exists from `out_ready` to `out_valid` or to the data outputs.

## Test plan
1. **Single result.** `out_ready`=1; channel 2 strobe with len 64 at cycle 10.
   - Expect `out_valid`=1, `out_port`=2, `out_frame_len`=64 at cycle 12 only. No drops.
2. **Simultaneous strobes.** All 4 channels strobe in one cycle with lens 10, 20, 30, 40; `out_ready`=1.
   - Expect four consecutive outputs: (0,10), (1,20), (2,30), (3,40).
3. **Round-robin fairness.** After a grant of channel 1, channels 0 and 2 become pending together.
   - Expect channel 2 granted first, then channel 0.
4. **Backpressure and drop.** `out_ready`=0; channel 0 strobes lens 1, 2, 3 on cycles 0, 2, 4.
   - Output holds 1 and the slot holds 2.
   - Strobe 3 is dropped: `drop[0]` pulses at cycle 5 and `drop_count[0]`=1.
   - Raise `out_ready`: expect 1 then 2, then `out_valid`=0.
5. **Counter saturation and clear.** `DROP_CNT_WIDTH`=8, 300 forced drops on channel 3.
   - Expect `drop_count[3]`=255.
   - `clear_drop` gives 0.
   - `clear_drop` in the same cycle as a drop gives 1.
6. **Reset mid-operation.** Slots pending and `out_valid`=1; assert `rst` for one cycle.
   - Next cycle: all outputs at reset values.
   - Then strobe channels 3 and 0 together: expect channel 0 granted first.
